// File: rtl/ir_pulse_meter.sv
// ir_pulse_meter
//   Front end of the IR receive path. Synchronises and glitch-filters the raw
//   IRDA_RXD line, measures every mark (low) and space (high) in ticks of
//   TICK_DIV clock cycles, and hands each completed pulse downstream as a
//   {level, length, overflow} record over a valid/ready handshake.
//
// Ports
//   CLOCK_50     in   system clock
//   reset        in   synchronous, active-high reset
//   IRDA_RXD     in   raw IR receiver output, asynchronous, idle high
//   rx_level     out  filtered line level
//   pulse_valid  out  record available
//   pulse_ready  in   consumer accepts the record when valid && ready
//   pulse_level  out  0 = mark (low), 1 = space (high)
//   pulse_len    out  pulse length in ticks, saturating
//   pulse_ovf    out  length saturated at 2^WIDTH-1
//   idle         out  FSM in IDLE
//   overrun      out  sticky: a record was dropped because the output was occupied
module ir_pulse_meter #(
  parameter int TICK_DIV   = 50,
  parameter int FILTER_LEN = 8,
  parameter int WIDTH      = 16,
  parameter int IDLE_US    = 20000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             IRDA_RXD,
  output logic             rx_level,
  output logic             pulse_valid,
  input  logic             pulse_ready,
  output logic             pulse_level,
  output logic [WIDTH-1:0] pulse_len,
  output logic             pulse_ovf,
  output logic             idle,
  output logic             overrun
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [WIDTH-1:0] LEN_MAX   = '1;
  localparam logic [WIDTH-1:0] IDLE_LEN  = WIDTH'(IDLE_US);
  localparam logic [PW-1:0]    PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [FW-1:0]    FILT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MARK,
    S_SPACE
  } state_t;

  state_t state, state_nxt;

  logic             sync0, sync1;
  logic [FW-1:0]    filt_cnt;
  logic             rx_prev;
  logic             fall, rise, edge_any;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [WIDTH-1:0] len, len_nxt;
  logic             ovf, ovf_nxt;
  logic             emit, emit_level, emit_ovf;
  logic [WIDTH-1:0] emit_len;
  logic             can_load;

  // Two-flop synchroniser; idles high so reset looks like an idle line.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
    end else begin
      sync0 <= IRDA_RXD;
      sync1 <= sync0;
    end
  end

  // Level changes only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      filt_cnt <= '0;
      rx_level <= 1'b1;
    end else if (sync1 == rx_level) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      filt_cnt <= '0;
      rx_level <= ~rx_level;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) rx_prev <= 1'b1;
    else       rx_prev <= rx_level;
  end

  assign fall     = rx_prev & ~rx_level;
  assign rise     = ~rx_prev & rx_level;
  assign edge_any = fall | rise;
  assign tick     = (presc == PRE_LAST);

  // The record captures the counter value including this cycle's tick, so
  // the reported length is floor(cycles_between_edges / TICK_DIV).
  always_comb begin
    len_nxt = len;
    ovf_nxt = ovf;
    if (tick) begin
      if (len == LEN_MAX) ovf_nxt = 1'b1;
      else                len_nxt = len + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || edge_any) begin
      presc <= '0;
      len   <= '0;
      ovf   <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      len   <= len_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    emit       = 1'b0;
    emit_level = 1'b0;
    emit_len   = len_nxt;
    emit_ovf   = ovf_nxt;
    case (state)
      S_IDLE: begin
        if (fall) state_nxt = S_MARK;
      end
      S_MARK: begin
        if (rise) begin
          state_nxt  = S_SPACE;
          emit       = 1'b1;
          emit_level = 1'b0;
        end
      end
      S_SPACE: begin
        // A fall in the timeout cycle takes priority over the timeout.
        if (fall) begin
          state_nxt  = S_MARK;
          emit       = 1'b1;
          emit_level = 1'b1;
        end else if (len == IDLE_LEN) begin
          state_nxt  = S_IDLE;
          emit       = 1'b1;
          emit_level = 1'b1;
          emit_len   = IDLE_LEN;
          emit_ovf   = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign idle     = (state == S_IDLE);
  assign can_load = ~pulse_valid | pulse_ready;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pulse_valid <= 1'b0;
      pulse_level <= 1'b0;
      pulse_len   <= '0;
      pulse_ovf   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (emit && can_load) begin
        pulse_valid <= 1'b1;
        pulse_level <= emit_level;
        pulse_len   <= emit_len;
        pulse_ovf   <= emit_ovf;
      end else if (pulse_valid && pulse_ready) begin
        pulse_valid <= 1'b0;
      end
      if (emit && !can_load) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ir_pulse_meter.sv
// tb_ir_pulse_meter
//   Self-checking bench for ir_pulse_meter, run with a scaled-down tick
//   (TICK_DIV=4, WIDTH=10, IDLE_US=200) so every scenario stays short.
module tb_ir_pulse_meter;

  localparam int T      = 4;
  localparam int FL     = 8;
  localparam int W      = 10;
  localparam int IDLE   = 200;
  localparam int MAXLEN = (1 << W) - 1;
  localparam int TO_CYC = IDLE * T;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rxd = 1'b1;
  logic         pulse_ready = 1'b0;
  logic         rx_level, pulse_valid, pulse_level, pulse_ovf, idle, overrun;
  logic [W-1:0] pulse_len;

  always #5 clk = ~clk;

  ir_pulse_meter #(
    .TICK_DIV  (T),
    .FILTER_LEN(FL),
    .WIDTH     (W),
    .IDLE_US   (IDLE)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .IRDA_RXD   (rxd),
    .rx_level   (rx_level),
    .pulse_valid(pulse_valid),
    .pulse_ready(pulse_ready),
    .pulse_level(pulse_level),
    .pulse_len  (pulse_len),
    .pulse_ovf  (pulse_ovf),
    .idle       (idle),
    .overrun    (overrun)
  );

  typedef struct packed {
    logic         lvl;
    logic [W-1:0] len;
    logic         ovf;
  } rec_t;

  rec_t rcv[$];
  rec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   rdy_mode = 1'b0;
  bit   rdy_val = 1'b0;
  int   pend = 0;
  bit   saw_low = 1'b0;
  bit   model_active = 1'b0;

  function automatic rec_t mk(input bit lvl, input int len, input bit ovf);
    rec_t r;
    r.lvl = lvl;
    r.len = W'(len);
    r.ovf = ovf;
    return r;
  endfunction

  // Records are taken where the handshake completes at the following edge.
  always @(negedge clk) begin
    if (pulse_valid === 1'b1 && pulse_ready === 1'b1)
      rcv.push_back(mk(pulse_level, int'(pulse_len), pulse_ovf));
    if (rx_level === 1'b0) saw_low = 1'b1;
  end

  // Ready driver: fixed level, or random with a bounded stall.
  always @(posedge clk) begin
    #1;
    if (pulse_valid === 1'b1 && pulse_ready !== 1'b1) pend++;
    else pend = 0;
    if (rdy_mode) pulse_ready = (pend >= 3) || ($urandom % 2 == 1);
    else          pulse_ready = rdy_val;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // Reference model: one completed raw segment of d cycles at level lvl.
  task automatic model_seg(input bit lvl, input int d);
    int l;
    l = d / T;
    if (!lvl) begin
      exp_q.push_back(mk(1'b0, (l > MAXLEN) ? MAXLEN : l, l > MAXLEN));
      model_active = 1'b1;
    end else if (model_active) begin
      if (d <= TO_CYC) begin
        exp_q.push_back(mk(1'b1, l, 1'b0));
      end else begin
        exp_q.push_back(mk(1'b1, IDLE, 1'b0));
        model_active = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    rxd = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic seg(input logic lvl, input int n);
    drive(lvl, n);
    model_seg(lvl, n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_active = 1'b0;
  endtask

  task automatic test_reset();
    rxd = 1'b1;
    do_reset();
    checks++; if (rx_level !== 1'b1) begin errors++; $display("FAIL reset_rx_level: got %b want 1", rx_level); end
    checks++; if (pulse_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pulse_valid); end
    checks++; if (pulse_level !== 1'b0) begin errors++; $display("FAIL reset_level: got %b want 0", pulse_level); end
    checks++; if (pulse_len !== '0) begin errors++; $display("FAIL reset_len: got %0d want 0", pulse_len); end
    checks++; if (pulse_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", pulse_ovf); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_glitch();
    rcv.delete();
    rdy_val = 1'b1;
    drive(1'b1, 10);
    saw_low = 1'b0;
    drive(1'b0, 5);
    drive(1'b1, 60);
    drive(1'b0, FL - 1);
    drive(1'b1, 60);
    checks++; if (saw_low !== 1'b0) begin errors++; $display("FAIL glitch_rx_level: got low seen=%b want 0", saw_low); end
    checks++; if (rcv.size() != 0) begin errors++; $display("FAIL glitch_records: got %0d want 0", rcv.size()); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL glitch_idle: got %b want 1", idle); end
    checks++; if (pulse_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", pulse_valid); end
  endtask

  task automatic test_lead();
    rcv.delete();
    exp_q.delete();
    exp_q.push_back(mk(1'b0, 90, 1'b0));
    exp_q.push_back(mk(1'b1, 45, 1'b0));
    exp_q.push_back(mk(1'b0, 10, 1'b0));
    exp_q.push_back(mk(1'b1, IDLE, 1'b0));
    drive(1'b0, 360);
    drive(1'b1, 180);
    drive(1'b0, 40);
    drive(1'b1, TO_CYC + 60);
    checks++; if (rcv.size() != 4) begin errors++; $display("FAIL lead_count: got %0d want 4", rcv.size()); end
    for (int i = 0; i < 4 && i < rcv.size(); i++) begin
      checks++;
      if (rcv[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL lead_rec[%0d]: got lvl=%b len=%0d ovf=%b want lvl=%b len=%0d ovf=%b",
                 i, rcv[i].lvl, rcv[i].len, rcv[i].ovf, exp_q[i].lvl, exp_q[i].len, exp_q[i].ovf);
      end
    end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL lead_idle: got %b want 1", idle); end
    checks++; if (pulse_valid !== 1'b0) begin errors++; $display("FAIL lead_valid_drop: got %b want 0", pulse_valid); end
  endtask

  task automatic test_random();
    int nmark;
    rdy_mode = 1'b1;
    for (int f = 0; f < 4; f++) begin
      rcv.delete();
      exp_q.delete();
      nmark = int'($urandom_range(1, 5));
      for (int m = 0; m < nmark; m++) begin
        seg(1'b0, int'($urandom_range(12, 400)));
        if (m != nmark - 1) seg(1'b1, int'($urandom_range(12, TO_CYC - 8)));
      end
      seg(1'b1, TO_CYC + 60 + int'($urandom_range(0, 40)));
      checks++;
      if (rcv.size() != exp_q.size()) begin
        errors++;
        $display("FAIL random_count[f%0d]: got %0d want %0d", f, rcv.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rcv.size(); i++) begin
        checks++;
        if (rcv[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random_rec[f%0d.%0d]: got lvl=%b len=%0d ovf=%b want lvl=%b len=%0d ovf=%b",
                   f, i, rcv[i].lvl, rcv[i].len, rcv[i].ovf, exp_q[i].lvl, exp_q[i].len, exp_q[i].ovf);
        end
      end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL random_idle[f%0d]: got %b want 1", f, idle); end
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL random_overrun: got %b want 0", overrun); end
    rdy_mode = 1'b0;
    rdy_val  = 1'b1;
    drive(1'b1, 4);
  endtask

  task automatic test_saturation();
    rcv.delete();
    drive(1'b0, 4400);
    drive(1'b1, TO_CYC + 60);
    checks++; if (rcv.size() != 2) begin errors++; $display("FAIL sat_count: got %0d want 2", rcv.size()); end
    if (rcv.size() >= 1) begin
      checks++;
      if (rcv[0] !== mk(1'b0, MAXLEN, 1'b1)) begin
        errors++;
        $display("FAIL sat_rec: got lvl=%b len=%0d ovf=%b want lvl=0 len=%0d ovf=1",
                 rcv[0].lvl, rcv[0].len, rcv[0].ovf, MAXLEN);
      end
    end
  endtask

  task automatic test_overrun();
    rcv.delete();
    rdy_val = 1'b0;
    drive(1'b1, 4);
    drive(1'b0, 40);
    drive(1'b1, 40);
    drive(1'b0, 40);
    drive(1'b1, TO_CYC + 60);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    checks++; if (pulse_valid !== 1'b1) begin errors++; $display("FAIL ovr_held_valid: got %b want 1", pulse_valid); end
    checks++; if (pulse_level !== 1'b0) begin errors++; $display("FAIL ovr_held_level: got %b want 0", pulse_level); end
    checks++; if (pulse_len !== W'(10)) begin errors++; $display("FAIL ovr_held_len: got %0d want 10", pulse_len); end
    checks++; if (rcv.size() != 0) begin errors++; $display("FAIL ovr_early_accept: got %0d want 0", rcv.size()); end
    rdy_val = 1'b1;
    drive(1'b1, 5);
    checks++; if (rcv.size() != 1) begin errors++; $display("FAIL ovr_accept_count: got %0d want 1", rcv.size()); end
    if (rcv.size() >= 1) begin
      checks++;
      if (rcv[0] !== mk(1'b0, 10, 1'b0)) begin
        errors++;
        $display("FAIL ovr_accept_rec: got lvl=%b len=%0d ovf=%b want lvl=0 len=10 ovf=0",
                 rcv[0].lvl, rcv[0].len, rcv[0].ovf);
      end
    end
    checks++; if (pulse_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop: got %b want 0", pulse_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid_pulse();
    rcv.delete();
    exp_q.delete();
    rdy_val = 1'b0;
    drive(1'b1, 4);
    drive(1'b0, 40);
    drive(1'b1, 40);
    drive(1'b0, 300);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL mid_setup_overrun: got %b want 1", overrun); end
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (rx_level !== 1'b1) begin errors++; $display("FAIL mid_rx_level: got %b want 1", rx_level); end
    checks++; if (pulse_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", pulse_valid); end
    checks++; if (pulse_len !== '0) begin errors++; $display("FAIL mid_len: got %0d want 0", pulse_len); end
    checks++; if (pulse_level !== 1'b0) begin errors++; $display("FAIL mid_level: got %b want 0", pulse_level); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle: got %b want 1", idle); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun: got %b want 0", overrun); end
    reset = 1'b0;
    rdy_val = 1'b1;
    exp_q.push_back(mk(1'b0, 50, 1'b0));
    exp_q.push_back(mk(1'b1, IDLE, 1'b0));
    drive(1'b0, 200);
    drive(1'b1, TO_CYC + 60);
    checks++; if (rcv.size() != 2) begin errors++; $display("FAIL mid_count: got %0d want 2", rcv.size()); end
    for (int i = 0; i < 2 && i < rcv.size(); i++) begin
      checks++;
      if (rcv[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mid_rec[%0d]: got lvl=%b len=%0d ovf=%b want lvl=%b len=%0d ovf=%b",
                 i, rcv[i].lvl, rcv[i].len, rcv[i].ovf, exp_q[i].lvl, exp_q[i].len, exp_q[i].ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_lead();
    test_random();
    test_saturation();
    test_overrun();
    do_reset();
    test_reset_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
